// File: rtl/skolem_chk_pkg.sv
// Shared definitions for the Skolem urem checker.
//   CHK_W      operand width of the bvule/bvurem0 Skolem core
//   CHK_IDX_W  width of a bit index into a CHK_W-bit operand
//   state_t    sequencer states IDLE -> APPLY -> DIV -> DONE
package skolem_chk_pkg;

  localparam int CHK_W     = 4;
  localparam int CHK_IDX_W = $clog2(CHK_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DIV   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/bv_urem_serial.sv
// Serial restoring remainder unit, one dividend bit per cycle, MSB first.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       1-cycle pulse: clear remainder, point at dividend MSB
//   dividend    W-bit dividend, held stable for the whole run
//   divisor     W-bit divisor, held stable for the whole run
//   done        1-cycle pulse the cycle after the last iteration
//   rem         remainder, valid from done until the next start
// With divisor==0 the compare always succeeds and the unit simply shifts
// the dividend in, so rem ends equal to the dividend.
module bv_urem_serial
  import skolem_chk_pkg::*;
#(
  parameter int W     = CHK_W,
  parameter int IDX_W = CHK_IDX_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] rem
);

  logic [W-1:0]     rem_q;
  logic [W-1:0]     rem_d;
  logic [IDX_W-1:0] idx_q;
  logic             active_q;
  logic             done_q;
  logic [W:0]       shifted;
  logic             ge;

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    shifted = {rem_q, dividend[idx_q]};
    ge      = (shifted >= {1'b0, divisor});
    rem_d   = shifted[W-1:0];
    // The true difference is below the divisor, so the low W bits of the
    // subtraction are exact even though shifted is W+1 bits wide.
    if (ge) rem_d = shifted[W-1:0] - divisor;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q    <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else if (start) begin
      rem_q    <= '0;
      idx_q    <= IDX_W'(W - 1);
      active_q <= 1'b1;
      done_q   <= 1'b0;
    end else if (active_q) begin
      rem_q <= rem_d;
      if (idx_q == '0) begin
        active_q <= 1'b0;
        done_q   <= 1'b1;
      end else begin
        idx_q <= idx_q - 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign done = done_q;
  assign rem  = rem_q;

endmodule

// File: rtl/skolem_urem_checker.sv
// Sequencer/checker for the 4-bit bvule/bvurem0 Skolem core.
// Applies (s,t) to the external combinational core, captures x, recomputes
// x urem s serially and reports x, the remainder and whether rem <=u t.
// Optional macro: SKCHK_STATS_EN adds saturating chk_cnt/fail_cnt counters.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_s, req_t          divisor s and bound t
//   sk_s, sk_t            operands driven to the Skolem core (held after APPLY)
//   sk_x                  Skolem core output, sampled only in APPLY
//   rsp_valid/rsp_ready   response handshake
//   rsp_x, rsp_rem        captured x and x urem s (x when s==0)
//   rsp_ok                rsp_rem <=u t
//   busy                  state != IDLE
//   chk_cnt, fail_cnt     completed / failing checks (SKCHK_STATS_EN only)
module skolem_urem_checker
  import skolem_chk_pkg::*;
#(
  parameter int W = CHK_W
`ifdef SKCHK_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_s,
  input  logic [W-1:0] req_t,
  output logic [W-1:0] sk_s,
  output logic [W-1:0] sk_t,
  input  logic [W-1:0] sk_x,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_x,
  output logic [W-1:0] rsp_rem,
  output logic         rsp_ok,
  output logic         busy
`ifdef SKCHK_STATS_EN
  ,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] fail_cnt
`endif
);

  state_t       state_q;
  state_t       state_d;
  logic [W-1:0] x_r;
  logic [W-1:0] div_rem;
  logic [W-1:0] rem_final;
  logic         div_done;
  logic         accept;
  logic         rsp_hs;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign accept    = req_valid && req_ready;
  assign rsp_hs    = rsp_valid && rsp_ready;

  // SMT-LIB bvurem: x urem 0 = x.
  assign rem_final = (sk_s == '0) ? x_r : div_rem;

  bv_urem_serial #(
    .W     (W),
    .IDX_W ($clog2(W))
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (state_q == APPLY),
    .dividend (x_r),
    .divisor  (sk_s),
    .done     (div_done),
    .rem      (div_rem)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = APPLY;
      APPLY:   state_d = DIV;
      DIV:     if (div_done) state_d = DONE;
      DONE:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sk_s    <= '0;
      sk_t    <= '0;
      x_r     <= '0;
      rsp_x   <= '0;
      rsp_rem <= '0;
      rsp_ok  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sk_s <= req_s;
        sk_t <= req_t;
      end
      // Core has had the whole APPLY cycle to settle on the new operands.
      if (state_q == APPLY) x_r <= sk_x;
      if (state_q == DIV && div_done) begin
        rsp_x   <= x_r;
        rsp_rem <= rem_final;
        rsp_ok  <= (rem_final <= sk_t);
      end
    end
  end

`ifdef SKCHK_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_cnt  <= '0;
      fail_cnt <= '0;
    end else if (rsp_hs) begin
      if (chk_cnt != '1) chk_cnt <= chk_cnt + 1'b1;
      if (!rsp_ok && fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
    end
  end
`else
  logic unused_hs;
  assign unused_hs = rsp_hs;
`endif

endmodule

// File: tb/tb_skolem_urem_checker.sv
// Directed bench for skolem_urem_checker; the Skolem core is replaced by a
// bench variable core_x so faulty and correct x values can be injected.
module tb_skolem_urem_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_s;
  logic [3:0] req_t;
  logic [3:0] sk_s;
  logic [3:0] sk_t;
  logic [3:0] sk_x;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_x;
  logic [3:0] rsp_rem;
  logic       rsp_ok;
  logic       busy;
  logic [3:0] core_x;
`ifdef SKCHK_STATS_EN
  logic [15:0] chk_cnt;
  logic [15:0] fail_cnt;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  assign sk_x = core_x;

  always #5 clk = ~clk;

  skolem_urem_checker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_s     (req_s),
    .req_t     (req_t),
    .sk_s      (sk_s),
    .sk_t      (sk_t),
    .sk_x      (sk_x),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_x     (rsp_x),
    .rsp_rem   (rsp_rem),
    .rsp_ok    (rsp_ok),
    .busy      (busy)
`ifdef SKCHK_STATS_EN
    ,
    .chk_cnt   (chk_cnt),
    .fail_cnt  (fail_cnt)
`endif
  );

  // Issue one request from IDLE and count edges until rsp_valid (bounded).
  task automatic run_req(input logic [3:0] s, input logic [3:0] t,
                         input logic [3:0] x, output int lat);
    core_x    = x;
    req_s     = s;
    req_t     = t;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Accept the pending response in one cycle.
  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_s = 4'd0; req_t = 4'd0; core_x = 4'd0;
    #3;
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b exp 1", req_ready); else pass_cnt++;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b exp 0", rsp_valid); else pass_cnt++;
    total_cnt++; if ({rsp_x, rsp_rem, rsp_ok} !== 9'd0) $display("FAIL reset_rsp: got x=%0d rem=%0d ok=%b exp 0", rsp_x, rsp_rem, rsp_ok); else pass_cnt++;
    total_cnt++; if ({sk_s, sk_t} !== 8'd0) $display("FAIL reset_sk: got s=%0d t=%0d exp 0", sk_s, sk_t); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else pass_cnt++;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat;
    run_req(4'd3, 4'd1, 4'd4, lat);
    total_cnt++; if (lat !== 6) $display("FAIL basic_latency: got %0d exp 6", lat); else pass_cnt++;
    total_cnt++; if (rsp_x !== 4'd4) $display("FAIL basic_x: got %0d exp 4", rsp_x); else pass_cnt++;
    total_cnt++; if (rsp_rem !== 4'd1) $display("FAIL basic_rem: got %0d exp 1", rsp_rem); else pass_cnt++;
    total_cnt++; if (rsp_ok !== 1'b1) $display("FAIL basic_ok: got %b exp 1", rsp_ok); else pass_cnt++;
    total_cnt++; if ({sk_s, sk_t} !== {4'd3, 4'd1}) $display("FAIL basic_sk: got s=%0d t=%0d exp 3 1", sk_s, sk_t); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1 || req_ready !== 1'b0) $display("FAIL basic_busy: got busy=%b ready=%b exp 1 0", busy, req_ready); else pass_cnt++;
    take_rsp();
  endtask

  task automatic test_div_zero();
    int lat;
    run_req(4'd0, 4'd5, 4'd2, lat);
    total_cnt++; if (lat !== 6) $display("FAIL divzero_latency: got %0d exp 6", lat); else pass_cnt++;
    total_cnt++; if (rsp_rem !== 4'd2) $display("FAIL divzero_rem: got %0d exp 2", rsp_rem); else pass_cnt++;
    total_cnt++; if (rsp_ok !== 1'b1) $display("FAIL divzero_ok: got %b exp 1", rsp_ok); else pass_cnt++;
    take_rsp();
  endtask

  task automatic test_faulty_core();
    int lat;
    run_req(4'd4, 4'd2, 4'd7, lat);
    total_cnt++; if (lat !== 6) $display("FAIL faulty_latency: got %0d exp 6", lat); else pass_cnt++;
    total_cnt++; if (rsp_rem !== 4'd3) $display("FAIL faulty_rem: got %0d exp 3", rsp_rem); else pass_cnt++;
    total_cnt++; if (rsp_ok !== 1'b0) $display("FAIL faulty_ok: got %b exp 0", rsp_ok); else pass_cnt++;
    take_rsp();
`ifdef SKCHK_STATS_EN
    total_cnt++; if (fail_cnt !== 16'd1) $display("FAIL faulty_fail_cnt: got %0d exp 1", fail_cnt); else pass_cnt++;
    total_cnt++; if (chk_cnt !== 16'd3) $display("FAIL faulty_chk_cnt: got %0d exp 3", chk_cnt); else pass_cnt++;
`endif
  endtask

  task automatic test_backpressure();
    int lat;
    run_req(4'd6, 4'd5, 4'd13, lat);
    total_cnt++; if (lat !== 6) $display("FAIL hold_latency: got %0d exp 6", lat); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_s = 4'd1; req_t = 4'd1;
      @(posedge clk); #1;
      total_cnt++;
      if (rsp_valid !== 1'b1 || rsp_x !== 4'd13 || rsp_rem !== 4'd1 || rsp_ok !== 1'b1)
        $display("FAIL hold_stable[%0d]: got v=%b x=%0d rem=%0d ok=%b exp 1 13 1 1", i, rsp_valid, rsp_x, rsp_rem, rsp_ok);
      else pass_cnt++;
      total_cnt++;
      if (req_ready !== 1'b0 || sk_s !== 4'd6 || sk_t !== 4'd5)
        $display("FAIL hold_ignore[%0d]: got ready=%b s=%0d t=%0d exp 0 6 5", i, req_ready, sk_s, sk_t);
      else pass_cnt++;
    end
    req_valid = 1'b0;
    take_rsp();
    total_cnt++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL hold_release: got v=%b ready=%b busy=%b exp 0 1 0", rsp_valid, req_ready, busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int  lat;
    logic seen;
    core_x = 4'd9; req_s = 4'd5; req_t = 4'd0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;   // APPLY ends, divider started
    @(posedge clk); #1;   // first DIV iteration done
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1 || {sk_s, sk_t, rsp_x, rsp_rem, rsp_ok} !== 17'd0)
      $display("FAIL midreset_outputs: got busy=%b v=%b ready=%b s=%0d t=%0d x=%0d rem=%0d ok=%b exp all reset",
               busy, rsp_valid, req_ready, sk_s, sk_t, rsp_x, rsp_rem, rsp_ok);
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rsp_valid === 1'b1) seen = 1'b1;
    end
    total_cnt++; if (seen !== 1'b0) $display("FAIL midreset_no_rsp: got rsp_valid=1 exp 0"); else pass_cnt++;
    run_req(4'd5, 4'd0, 4'd10, lat);
    total_cnt++; if (lat !== 6) $display("FAIL midreset_latency: got %0d exp 6", lat); else pass_cnt++;
    total_cnt++;
    if (rsp_x !== 4'd10 || rsp_rem !== 4'd0 || rsp_ok !== 1'b1)
      $display("FAIL midreset_rsp: got x=%0d rem=%0d ok=%b exp 10 0 1", rsp_x, rsp_rem, rsp_ok);
    else pass_cnt++;
    take_rsp();
  endtask

  task automatic test_back_to_back();
    // s, t, x, expected rem, expected ok
    logic [3:0] vs [5] = '{4'd15, 4'd1, 4'd7, 4'd2, 4'd9};
    logic [3:0] vt [5] = '{4'd0,  4'd0, 4'd2, 4'd1, 4'd15};
    logic [3:0] vx [5] = '{4'd15, 4'd9, 4'd12, 4'd0, 4'd8};
    logic [3:0] er [5] = '{4'd0,  4'd0, 4'd5, 4'd0, 4'd8};
    logic       eo [5] = '{1'b1,  1'b1, 1'b0, 1'b1, 1'b1};
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_req(vs[i], vt[i], vx[i], lat);
      total_cnt++;
      if (lat !== 6 || rsp_x !== vx[i] || rsp_rem !== er[i] || rsp_ok !== eo[i])
        $display("FAIL b2b[%0d]: got lat=%0d x=%0d rem=%0d ok=%b exp 6 %0d %0d %b",
                 i, lat, rsp_x, rsp_rem, rsp_ok, vx[i], er[i], eo[i]);
      else pass_cnt++;
      take_rsp();
      total_cnt++; if (req_ready !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b exp 1", i, req_ready); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_faulty_core();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
